// File: rtl/om_writeback_sequencer_pkg.sv
// bf_pkg: shared Bellman-Ford widths, codes and sequencer state encoding.
package bf_pkg;
    localparam int ADDR_W = 13;
    localparam int ROW_W  = 128;
    localparam int WORD_W = 16;
    localparam int LANES  = ROW_W / WORD_W;
    localparam int LANE_W = $clog2(LANES);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] WM_BASE   = 13'h0000;
    localparam logic [WORD_W-1:0] INF_CODE  = 16'h7FFF;
    localparam logic [WORD_W-1:0] UNREACH   = 16'hFFFF;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  MAX_NODES = CNT_W'(1 << ADDR_W);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
    function automatic logic [WORD_W-1:0] map_dist(input logic [WORD_W-1:0] d);
        return d == INF_CODE ? UNREACH : d;
    endfunction
endpackage

// File: rtl/om_writeback_sequencer_if.sv
// om_writeback_sequencer_if: control, WM read port 2 and OM write port of the writeback sequencer.
interface om_writeback_sequencer_if;
    import bf_pkg::*;
    logic              start;
    logic [CNT_W-1:0]  node_count;
    logic              busy;
    logic              finish;
    logic [ADDR_W-1:0] wm_addr;
    logic [ROW_W-1:0]  wm_data;
    logic [ADDR_W-1:0] om_waddr;
    logic [WORD_W-1:0] om_wdata;
    logic              om_we;
    modport master (
        input  start, node_count, wm_data,
        output busy, finish, wm_addr, om_waddr, om_wdata, om_we
    );
    modport slave (
        output start, node_count, wm_data,
        input  busy, finish, wm_addr, om_waddr, om_wdata, om_we
    );
endinterface

// File: rtl/om_writeback_sequencer_lane_select.sv
// om_lane_select: picks one distance word out of a WM row and maps the internal infinity code.
module om_lane_select
    import bf_pkg::*;
(
    input  logic [ROW_W-1:0]  row_buf,
    input  logic [LANE_W-1:0] lane,
    output logic [WORD_W-1:0] word
);
    assign word = map_dist(row_buf[lane*WORD_W +: WORD_W]);
endmodule

// File: rtl/om_writeback_sequencer.sv
// om_writeback_sequencer: copies N packed WM distances into OM, one word per cycle, then raises finish.
module om_writeback_sequencer
    import bf_pkg::*;
(
    input logic clock,
    input logic reset,
    om_writeback_sequencer_if.master bus
);
    state_t            state;
    logic [CNT_W-1:0]  n;
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  n_req;
    logic [LANE_W-1:0] lane;
    logic [ROW_W-1:0]  row_buf;
    logic [WORD_W-1:0] word;
    logic              busy_q;
    logic              finish_q;
    logic              drain;

    om_lane_select u_sel (.row_buf(row_buf), .lane(lane), .word(word));

    always_comb begin
        n_req = bus.node_count > MAX_NODES ? MAX_NODES : bus.node_count;
        drain = state == DRAIN;
    end

    // During DRAIN the WM port already points at the next row so a lane wrap reloads without a bubble.
    assign bus.wm_addr  = WM_BASE + (drain ? ADDR_W'(idx[CNT_W-1:LANE_W]) + 1'b1 : '0);
    assign bus.om_we    = drain;
    assign bus.om_waddr = drain ? idx[ADDR_W-1:0] : '0;
    assign bus.om_wdata = drain ? word : '0;
    assign bus.busy     = busy_q;
    assign bus.finish   = finish_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            n        <= '0;
            idx      <= '0;
            lane     <= '0;
            row_buf  <= '0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (bus.start) begin
                    n        <= n_req;
                    state    <= n_req == '0 ? DONE : FETCH;
                    busy_q   <= n_req != '0;
                    finish_q <= n_req == '0;
                end
                FETCH: begin
                    row_buf <= bus.wm_data;
                    idx     <= '0;
                    lane    <= '0;
                    state   <= DRAIN;
                end
                DRAIN: begin
                    idx  <= idx + 1'b1;
                    lane <= lane == LAST_LANE ? '0 : lane + 1'b1;
                    if (lane == LAST_LANE) row_buf <= bus.wm_data;
                    if (idx == n - 1'b1) begin
                        state    <= DONE;
                        busy_q   <= 1'b0;
                        finish_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_om_writeback_sequencer.sv
// tb_om_writeback_sequencer: directed checks of timing, mapping, reset and start handling.
module tb_om_writeback_sequencer;
    import bf_pkg::*;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;
    int wcnt = 0;
    int hi = 0;
    int w0;
    int h0;
    logic [ROW_W-1:0]  r;
    logic [ROW_W-1:0]  wm [0:3];
    logic [WORD_W-1:0] om [0:8191];

    om_writeback_sequencer_if bus();
    om_writeback_sequencer dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;
    assign bus.wm_data = bus.wm_addr < 13'd4 ? wm[bus.wm_addr[1:0]] : '0;

    always @(posedge clock) if (bus.om_we === 1'b1) begin
        om[bus.om_waddr] <= bus.om_wdata;
        wcnt <= wcnt + 1;
        if (bus.om_waddr >= 13'd13 && bus.om_waddr <= 13'd15) hi <= hi + 1;
    end

    function automatic logic [ROW_W-1:0] mkrow(input int first);
        logic [ROW_W-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*WORD_W +: WORD_W] = WORD_W'(first + i);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input int cnt);
        bus.start = 1'b1;
        bus.node_count = CNT_W'(cnt);
        @(posedge clock);
        #1 bus.start = 1'b0;
    endtask

    task automatic drain(input int cnt, input int base);
        for (int k = 0; k < cnt; k++) begin
            @(posedge clock);
            #1;
            chk("we", bus.om_we, 1);
            chk("waddr", bus.om_waddr, k);
            chk("wdata", bus.om_wdata, base + k);
            chk("prefetch", bus.wm_addr, k / 8 + 1);
        end
        @(posedge clock);
        #1;
        chk("finish_end", bus.finish, 1);
        chk("busy_end", bus.busy, 0);
        chk("we_end", bus.om_we, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.node_count = '0;
        for (int i = 0; i < 4; i++) wm[i] = '0;
        #2;
        chk("rst_busy", bus.busy, 0);
        chk("rst_finish", bus.finish, 0);
        chk("rst_we", bus.om_we, 0);
        chk("rst_waddr", bus.om_waddr, 0);
        chk("rst_wdata", bus.om_wdata, 0);
        chk("rst_wm_addr", bus.wm_addr, 0);
        #10 reset = 1'b1;
        @(posedge clock);
        #1;
        w0 = wcnt;
        start_run(0);
        chk("n0_finish", bus.finish, 1);
        repeat (3) begin
            chk("n0_busy", bus.busy, 0);
            chk("n0_we", bus.om_we, 0);
            @(posedge clock);
            #1;
        end
        chk("n0_writes", wcnt - w0, 0);
        wm[0] = mkrow(1);
        start_run(8);
        chk("t1_finish_clr", bus.finish, 0);
        chk("t1_fetch_busy", bus.busy, 1);
        chk("t1_fetch_we", bus.om_we, 0);
        chk("t1_fetch_addr", bus.wm_addr, 0);
        drain(8, 1);
        wm[0] = mkrow(10);
        wm[1] = mkrow(18);
        h0 = hi;
        start_run(13);
        drain(13, 10);
        chk("t2_om12", om[12], 22);
        chk("t2_untouched", hi - h0, 0);
        r = mkrow(100);
        r[63:48] = 16'h7FFF;
        r[79:64] = 16'h7FFE;
        wm[0] = r;
        start_run(8);
        repeat (9) @(posedge clock);
        #1;
        chk("t3_finish", bus.finish, 1);
        chk("t3_om2", om[2], 102);
        chk("t3_om3_inf", om[3], 16'hFFFF);
        chk("t3_om4", om[4], 16'h7FFE);
        chk("t3_om5", om[5], 105);
        wm[0] = mkrow(30);
        start_run(8);
        repeat (6) @(posedge clock);
        #1;
        chk("t5_waddr5", bus.om_waddr, 5);
        chk("t5_wdata5", bus.om_wdata, 35);
        #2 reset = 1'b0;
        #1;
        chk("t5_we", bus.om_we, 0);
        chk("t5_busy", bus.busy, 0);
        chk("t5_finish", bus.finish, 0);
        chk("t5_waddr", bus.om_waddr, 0);
        chk("t5_wm_addr", bus.wm_addr, 0);
        @(negedge clock) reset = 1'b1;
        @(posedge clock);
        #1;
        wm[0] = mkrow(50);
        start_run(8);
        drain(8, 50);
        chk("t5_om0", om[0], 50);
        chk("t5_om7", om[7], 57);
        wm[0] = mkrow(200);
        wm[1] = mkrow(208);
        w0 = wcnt;
        start_run(16);
        repeat (3) @(posedge clock);
        #1;
        bus.start = 1'b1;
        bus.node_count = 14'd3;
        @(posedge clock);
        #1 bus.start = 1'b0;
        chk("t6_busy", bus.busy, 1);
        repeat (12) @(posedge clock);
        #1;
        chk("t6_last_we", bus.om_we, 1);
        chk("t6_last_waddr", bus.om_waddr, 15);
        chk("t6_last_wdata", bus.om_wdata, 215);
        chk("t6_finish_c17", bus.finish, 0);
        @(posedge clock);
        #1;
        chk("t6_finish_c18", bus.finish, 1);
        chk("t6_writes", wcnt - w0, 16);
        w0 = wcnt;
        start_run(3);
        chk("t6b_finish_clr", bus.finish, 0);
        drain(3, 200);
        chk("t6b_writes", wcnt - w0, 3);
        w0 = wcnt;
        start_run(14'h3FFF);
        for (int i = 0; i < 9000 && bus.finish !== 1'b1; i++) @(posedge clock);
        #1;
        chk("clamp_finish", bus.finish, 1);
        chk("clamp_writes", wcnt - w0, 8192);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
